// File: rtl/ctrl_pkg.sv
// Shared types and constants for the core sequencer.
//   state_e      : sequencer FSM states
//   inst_type_e  : decoded instruction class driven by the decoder
//   CAUSE_*      : trap cause encodings reported on trap_cause
//   is_load()/is_store() : classify an inst_type value
package ctrl_pkg;

  localparam int unsigned INST_TYPE_W = 3;

  typedef enum logic [2:0] {
    StStart,
    StFetch,
    StLoad,
    StStore,
    StExec,
    StHalt
  } state_e;

  typedef enum logic [INST_TYPE_W-1:0] {
    INST_ALU    = 3'd0,
    INST_BRANCH = 3'd1,
    INST_JUMP   = 3'd2,
    INST_CSR    = 3'd3,
    INST_LOAD   = 3'd4,
    INST_LOADU  = 3'd5,
    INST_STORE  = 3'd6,
    INST_EBREAK = 3'd7
  } inst_type_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_IFU_ERR = 2'd1;
  localparam logic [1:0] CAUSE_LSU_ERR = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  function automatic logic is_load(input logic [INST_TYPE_W-1:0] t);
    return (t == INST_LOAD) || (t == INST_LOADU);
  endfunction

  function automatic logic is_store(input logic [INST_TYPE_W-1:0] t);
    return t == INST_STORE;
  endfunction

endpackage

// File: rtl/ctrl_seq_wait_timer.sv
// wait_timer: counts cycles spent waiting for a bus response.
//   clock, reset : posedge clock, synchronous active-high reset
//   clear        : restart from 0 (state change)
//   enable       : count this cycle
//   expire       : count has reached TIMEOUT-1 (never asserted when TIMEOUT == 0)
module wait_timer #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TO_W'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (count_q == LastCnt);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle core sequencer (fetch -> load | store | exec).
//   clock, reset                 : posedge clock, synchronous active-high reset
//   ifu_respValid/ifu_respErr    : IFU response and bus error
//   lsu_respValid/lsu_respErr    : LSU response and bus error
//   inst_type                    : decoded class of the fetched instruction
//   ifu_reqValid, lsu_reqValid   : bus requests (combinational)
//   lsu_wen, pc_wen, reg_wen     : write strobes (combinational)
//   finished                     : pulse the cycle after a retirement
//   ebreak, trap, trap_cause     : sticky halt reasons
//   cycle_cnt, instret_cnt       : free-running cycle and retired-instruction counters
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ifu_respValid,
  input  logic                   ifu_respErr,
  input  logic                   lsu_respValid,
  input  logic                   lsu_respErr,
  input  logic [INST_TYPE_W-1:0] inst_type,
  output logic                   ifu_reqValid,
  output logic                   lsu_reqValid,
  output logic                   lsu_wen,
  output logic                   pc_wen,
  output logic                   reg_wen,
  output logic                   finished,
  output logic                   ebreak,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       instret_cnt
);

  state_e           state_q, state_d;
  logic             ifu_inflight_q, lsu_inflight_q;
  logic             ifu_ack, lsu_ack;
  logic             waiting, wait_ack, expire;
  logic             retire, ebreak_set, trap_set;
  logic [1:0]       cause_set;
  logic             finished_q, ebreak_q, trap_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] cycle_q, instret_q;

  // A response only counts when we actually have a request outstanding.
  assign ifu_ack = ifu_respValid & ifu_inflight_q;
  assign lsu_ack = lsu_respValid & lsu_inflight_q;

  assign waiting  = (state_q == StFetch) || (state_q == StLoad) || (state_q == StStore);
  assign wait_ack = (state_q == StFetch) ? ifu_ack : lsu_ack;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable (waiting & ~wait_ack),
    .expire (expire)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StStart;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and event decode
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ebreak_set = 1'b0;
    trap_set   = 1'b0;
    cause_set  = CAUSE_NONE;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        if (ifu_ack) begin
          if (ifu_respErr) begin
            state_d   = StHalt;
            trap_set  = 1'b1;
            cause_set = CAUSE_IFU_ERR;
          end else if (is_load(inst_type)) begin
            state_d = StLoad;
          end else if (is_store(inst_type)) begin
            state_d = StStore;
          end else begin
            state_d = StExec;
          end
        end else if (expire) begin
          state_d   = StHalt;
          trap_set  = 1'b1;
          cause_set = CAUSE_TIMEOUT;
        end
      end
      StLoad, StStore: begin
        if (lsu_ack) begin
          if (lsu_respErr) begin
            state_d   = StHalt;
            trap_set  = 1'b1;
            cause_set = CAUSE_LSU_ERR;
          end else if (state_q == StLoad) begin
            state_d = StExec;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (expire) begin
          state_d   = StHalt;
          trap_set  = 1'b1;
          cause_set = CAUSE_TIMEOUT;
        end
      end
      StExec: begin
        retire = 1'b1;
        if (inst_type == INST_EBREAK) begin
          state_d    = StHalt;
          ebreak_set = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StStart;
    endcase
  end

  // Request and strobe outputs; held low while reset is asserted.
  always_comb begin
    ifu_reqValid = 1'b0;
    lsu_reqValid = 1'b0;
    lsu_wen      = 1'b0;
    pc_wen       = 1'b0;
    reg_wen      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StStart: ifu_reqValid = 1'b1;
        StFetch: begin
          if (!ifu_ack) begin
            ifu_reqValid = 1'b1;
          end else if (!ifu_respErr) begin
            pc_wen = 1'b1;
            if (is_load(inst_type)) begin
              lsu_reqValid = 1'b1;
            end else if (is_store(inst_type)) begin
              lsu_reqValid = 1'b1;
              lsu_wen      = 1'b1;
            end else begin
              reg_wen = 1'b1;
            end
          end
        end
        StLoad: begin
          if (!lsu_ack) begin
            lsu_reqValid = 1'b1;
          end else if (!lsu_respErr) begin
            reg_wen = 1'b1;
          end
        end
        StStore: begin
          if (!lsu_ack) begin
            lsu_reqValid = 1'b1;
            lsu_wen      = 1'b1;
          end else if (!lsu_respErr) begin
            ifu_reqValid = 1'b1;
          end
        end
        StExec:  ifu_reqValid = (inst_type != INST_EBREAK);
        default: ;
      endcase
    end
  end

  // Inflight tracking, sticky flags and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      ifu_inflight_q <= 1'b0;
      lsu_inflight_q <= 1'b0;
      finished_q     <= 1'b0;
      ebreak_q       <= 1'b0;
      trap_q         <= 1'b0;
      cause_q        <= CAUSE_NONE;
      cycle_q        <= '0;
      instret_q      <= '0;
    end else begin
      ifu_inflight_q <= ifu_reqValid | (ifu_inflight_q & ~ifu_ack);
      lsu_inflight_q <= lsu_reqValid | (lsu_inflight_q & ~lsu_ack);
      finished_q     <= retire;
      if (ebreak_set) begin
        ebreak_q <= 1'b1;
      end
      if (trap_set && !trap_q) begin
        trap_q  <= 1'b1;
        cause_q <= cause_set;
      end
      if (state_q != StHalt) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign finished    = finished_q;
  assign ebreak      = ebreak_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq. Two instances share all inputs: u_dut_a (CNT_W=4, TIMEOUT=8)
// and u_dut_b (CNT_W=64, TIMEOUT=0). The bus responder follows u_dut_a's requests.
module tb_ctrl_seq;
  import ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic ifu_respValid, ifu_respErr, lsu_respValid, lsu_respErr;
  logic [INST_TYPE_W-1:0] inst_type;

  logic a_ifu_req, a_lsu_req, a_lsu_wen, a_pc_wen, a_reg_wen, a_fin, a_ebreak, a_trap;
  logic [1:0] a_cause;
  logic [3:0] a_cycle, a_instret;
  logic b_ifu_req, b_lsu_req, b_lsu_wen, b_pc_wen, b_reg_wen, b_fin, b_ebreak, b_trap;
  logic [1:0] b_cause;
  logic [63:0] b_cycle, b_instret;

  always #5 clock = ~clock;

  ctrl_seq #(.CNT_W(4), .TIMEOUT(8)) u_dut_a (
    .clock(clock), .reset(reset),
    .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
    .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr), .inst_type(inst_type),
    .ifu_reqValid(a_ifu_req), .lsu_reqValid(a_lsu_req), .lsu_wen(a_lsu_wen),
    .pc_wen(a_pc_wen), .reg_wen(a_reg_wen), .finished(a_fin), .ebreak(a_ebreak),
    .trap(a_trap), .trap_cause(a_cause), .cycle_cnt(a_cycle), .instret_cnt(a_instret)
  );

  ctrl_seq #(.CNT_W(64), .TIMEOUT(0)) u_dut_b (
    .clock(clock), .reset(reset),
    .ifu_respValid(ifu_respValid), .ifu_respErr(ifu_respErr),
    .lsu_respValid(lsu_respValid), .lsu_respErr(lsu_respErr), .inst_type(inst_type),
    .ifu_reqValid(b_ifu_req), .lsu_reqValid(b_lsu_req), .lsu_wen(b_lsu_wen),
    .pc_wen(b_pc_wen), .reg_wen(b_reg_wen), .finished(b_fin), .ebreak(b_ebreak),
    .trap(b_trap), .trap_cause(b_cause), .cycle_cnt(b_cycle), .instret_cnt(b_instret)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Responder program and knobs
  logic [INST_TYPE_W-1:0] prog [0:31];
  int   prog_len, prog_idx, ifu_stall, lsu_stall, ifu_err_at;
  bit   lsu_err, lsu_fails;
  bit   ifu_pend, lsu_pend;
  int   ifu_wait, lsu_wait;
  logic [63:0] exp_ret;
  logic [63:0] sb [$];
  int   n_pc, n_reg, n_lsu, n_wen, n_ifu, n_fin;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ifu_respValid = 1'b0; ifu_respErr = 1'b0;
    lsu_respValid = 1'b0; lsu_respErr = 1'b0;
    inst_type = INST_ALU;
    ifu_pend = 1'b0; lsu_pend = 1'b0; ifu_wait = 0; lsu_wait = 0;
    prog_idx = 0; prog_len = 0; ifu_stall = 0; lsu_stall = 0; ifu_err_at = -1;
    lsu_err = 1'b0; lsu_fails = 1'b0;
    sb.delete(); exp_ret = 64'd0;
    n_pc = 0; n_reg = 0; n_lsu = 0; n_wen = 0; n_ifu = 0; n_fin = 0;
    @(negedge clock);
    #1;
    check_eq("rst_ifu_req", 64'(a_ifu_req), 64'd0);
    check_eq("rst_lsu_req", 64'(a_lsu_req), 64'd0);
    check_eq("rst_lsu_wen", 64'(a_lsu_wen), 64'd0);
    check_eq("rst_pc_wen", 64'(a_pc_wen), 64'd0);
    check_eq("rst_reg_wen", 64'(a_reg_wen), 64'd0);
    check_eq("rst_finished", 64'(a_fin), 64'd0);
    check_eq("rst_ebreak", 64'(a_ebreak), 64'd0);
    check_eq("rst_trap", 64'(a_trap), 64'd0);
    check_eq("rst_cause", 64'(a_cause), 64'(CAUSE_NONE));
    check_eq("rst_cycle", 64'(a_cycle), 64'd0);
    check_eq("rst_instret", 64'(a_instret), 64'd0);
    check_eq("rst_b_trap", 64'(b_trap), 64'd0);
    check_eq("rst_b_instret", b_instret, 64'd0);
    reset = 1'b0;
  endtask

  // One iteration per clock: drive responses, observe, update the responder, next cycle.
  task automatic run_cycles(input int n);
    logic is_mem;
    logic [63:0] exp;
    for (int c = 0; c < n; c++) begin
      ifu_respValid = 1'b0; ifu_respErr = 1'b0;
      lsu_respValid = 1'b0; lsu_respErr = 1'b0;
      if (ifu_pend && ifu_wait >= ifu_stall && prog_idx < prog_len) begin
        ifu_respValid = 1'b1;
        inst_type = prog[prog_idx];
        is_mem = (prog[prog_idx] == INST_LOAD) || (prog[prog_idx] == INST_LOADU) ||
                 (prog[prog_idx] == INST_STORE);
        if (prog_idx == ifu_err_at) begin
          ifu_respErr = 1'b1;
        end else if (!(is_mem && lsu_fails)) begin
          exp_ret = exp_ret + 64'd1;
          sb.push_back(exp_ret);
        end
        prog_idx++;
      end
      if (lsu_pend && lsu_wait >= lsu_stall) begin
        lsu_respValid = 1'b1;
        lsu_respErr   = lsu_err;
      end
      #1;
      n_pc  += int'(a_pc_wen);
      n_reg += int'(a_reg_wen);
      n_lsu += int'(a_lsu_req);
      n_wen += int'(a_lsu_wen);
      n_ifu += int'(a_ifu_req);
      n_fin += int'(a_fin);
      if (a_fin) begin
        check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check_eq("sb_instret_a", 64'(a_instret), 64'(exp[3:0]));
          check_eq("sb_instret_b", b_instret, exp);
          check_eq("sb_finished_b", 64'(b_fin), 64'd1);
        end
      end
      if (ifu_respValid) ifu_pend = 1'b0;
      else if (ifu_pend) ifu_wait++;
      if (a_ifu_req && !ifu_pend) begin ifu_pend = 1'b1; ifu_wait = 0; end
      if (lsu_respValid) lsu_pend = 1'b0;
      else if (lsu_pend) lsu_wait++;
      if (a_lsu_req && !lsu_pend) begin lsu_pend = 1'b1; lsu_wait = 0; end
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1;
    ifu_respValid = 1'b0; ifu_respErr = 1'b0;
    lsu_respValid = 1'b0; lsu_respErr = 1'b0;
    inst_type = INST_ALU;

    // ALU stream, zero-wait IFU
    do_reset();
    prog[0] = INST_ALU; prog[1] = INST_JUMP; prog[2] = INST_BRANCH; prog_len = 3;
    run_cycles(10);
    check_eq("alu_finished", 64'(n_fin), 64'd3);
    check_eq("alu_pc_wen", 64'(n_pc), 64'd3);
    check_eq("alu_reg_wen", 64'(n_reg), 64'd3);
    check_eq("alu_instret", 64'(a_instret), 64'd3);
    check_eq("alu_trap", 64'(a_trap), 64'd0);
    check_eq("alu_sb_drain", 64'(sb.size()), 64'd0);

    // Load with LSU wait: request visible 5 cycles, write on accept
    do_reset();
    prog[0] = INST_LOADU; prog_len = 1; lsu_stall = 4;
    run_cycles(10);
    check_eq("load_lsu_req", 64'(n_lsu), 64'd5);
    check_eq("load_reg_wen", 64'(n_reg), 64'd1);
    check_eq("load_lsu_wen", 64'(n_wen), 64'd0);
    check_eq("load_instret", 64'(a_instret), 64'd1);
    check_eq("load_finished", 64'(n_fin), 64'd1);

    // Store then EBREAK; only the EBREAK fetch writes the register file
    do_reset();
    prog[0] = INST_STORE; prog[1] = INST_EBREAK; prog_len = 2; lsu_stall = 1;
    run_cycles(8);
    check_eq("st_reg_wen", 64'(n_reg), 64'd1);
    check_eq("st_lsu_wen", 64'(n_wen), 64'd2);
    check_eq("st_ebreak", 64'(a_ebreak), 64'd1);
    check_eq("st_trap", 64'(a_trap), 64'd0);
    check_eq("st_instret", 64'(a_instret), 64'd2);
    check_eq("st_cycle", 64'(a_cycle), 64'd6);
    n_ifu = 0;
    run_cycles(5);
    check_eq("halt_ifu_req", 64'(n_ifu), 64'd0);
    check_eq("halt_cycle_frozen", 64'(a_cycle), 64'd6);
    check_eq("halt_b_cycle_frozen", b_cycle, 64'd6);
    check_eq("st_sb_drain", 64'(sb.size()), 64'd0);

    // IFU bus error on the second fetch
    do_reset();
    prog[0] = INST_ALU; prog[1] = INST_ALU; prog_len = 2; ifu_err_at = 1;
    run_cycles(6);
    check_eq("ifu_err_trap", 64'(a_trap), 64'd1);
    check_eq("ifu_err_cause", 64'(a_cause), 64'(CAUSE_IFU_ERR));
    check_eq("ifu_err_pc_wen", 64'(n_pc), 64'd1);
    check_eq("ifu_err_instret", 64'(a_instret), 64'd1);
    check_eq("ifu_err_ebreak", 64'(a_ebreak), 64'd0);

    // Response on the timeout cycle is accepted normally
    do_reset();
    prog[0] = INST_LOAD; prog_len = 1; lsu_stall = 7;
    run_cycles(13);
    check_eq("to_edge_trap", 64'(a_trap), 64'd0);
    check_eq("to_edge_instret", 64'(a_instret), 64'd1);
    check_eq("to_edge_sb_drain", 64'(sb.size()), 64'd0);

    // LSU error on the timeout cycle: error wins
    do_reset();
    prog[0] = INST_LOAD; prog_len = 1; lsu_stall = 7; lsu_err = 1'b1; lsu_fails = 1'b1;
    run_cycles(13);
    check_eq("lsu_err_trap", 64'(a_trap), 64'd1);
    check_eq("lsu_err_cause", 64'(a_cause), 64'(CAUSE_LSU_ERR));
    check_eq("lsu_err_reg_wen", 64'(n_reg), 64'd0);
    check_eq("lsu_err_instret", 64'(a_instret), 64'd0);

    // LSU never answers: a halts after 8 LOAD cycles, b keeps waiting
    do_reset();
    prog[0] = INST_LOAD; prog_len = 1; lsu_stall = 1000; lsu_fails = 1'b1;
    run_cycles(40);
    check_eq("to_trap", 64'(a_trap), 64'd1);
    check_eq("to_cause", 64'(a_cause), 64'(CAUSE_TIMEOUT));
    check_eq("to_lsu_req", 64'(n_lsu), 64'd9);
    check_eq("to_cycle", 64'(a_cycle), 64'd10);
    check_eq("to_b_trap", 64'(b_trap), 64'd0);
    check_eq("to_b_waiting", 64'(b_lsu_req), 64'd1);
    check_eq("to_b_cycle", b_cycle, 64'd40);

    // Reset mid-fetch, stale response in the following START cycle
    do_reset();
    prog[0] = INST_ALU; prog_len = 1; ifu_stall = 100;
    run_cycles(3);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ifu_respValid = 1'b1;
    inst_type = INST_ALU;
    #1;
    check_eq("rmf_start_req", 64'(a_ifu_req), 64'd1);
    check_eq("rmf_start_pc_wen", 64'(a_pc_wen), 64'd0);
    check_eq("rmf_start_reg_wen", 64'(a_reg_wen), 64'd0);
    @(negedge clock);
    ifu_respValid = 1'b0;
    #1;
    check_eq("rmf_fetch_req", 64'(a_ifu_req), 64'd1);
    check_eq("rmf_fetch_pc_wen", 64'(a_pc_wen), 64'd0);
    check_eq("rmf_instret", 64'(a_instret), 64'd0);
    ifu_pend = 1'b1; ifu_wait = 0; ifu_stall = 0; prog_idx = 0;
    sb.delete(); exp_ret = 64'd0; n_fin = 0;
    @(negedge clock);
    run_cycles(5);
    check_eq("rmf_restart_instret", 64'(a_instret), 64'd1);
    check_eq("rmf_restart_finished", 64'(n_fin), 64'd1);

    // 17 retirements: 4-bit counter wraps to 1, 64-bit reaches 17
    do_reset();
    for (int i = 0; i < 17; i++) prog[i] = INST_CSR;
    prog_len = 17;
    run_cycles(38);
    check_eq("wrap_instret_a", 64'(a_instret), 64'd1);
    check_eq("wrap_instret_b", b_instret, 64'd17);
    check_eq("wrap_finished", 64'(n_fin), 64'd17);
    check_eq("wrap_sb_drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised multi-cycle core sequencer. It drives the fetch → (load | store | exec) instruction cycle over the IFU and LSU valid/response handshakes, and generates the register-file, PC and LSU write enables. Beyond plain sequencing it adds:
- bus-error and request-timeout detection, with a sticky trap and cause code;
- a terminal HALT state for EBREAK or trap;
- cycle and retired-instruction counters.

It sits between the decoder (`inst_type`) and the IFU/LSU bus adapters in the SoC core.

## Interface
Parameters:
- `CNT_W`, 64: width of `cycle_cnt` / `instret_cnt`.
- `TIMEOUT`, 256: maximum cycles waiting for a response. 0 disables the timeout.
- `TO_W`, `$clog2(TIMEOUT+1)`: timeout counter width (derived; floor of 1).

Ports:
- `clock` in 1: sole clock. All logic is on the posedge.
- `reset` in 1: synchronous, active-high.
- `ifu_respValid` in 1: IFU response.
- `ifu_respErr` in 1: IFU bus error; qualified by `ifu_respValid`.
- `lsu_respValid` in 1: LSU response.
- `lsu_respErr` in 1: LSU bus error; qualified by `lsu_respValid`.
- `inst_type` in `INST_TYPE_W`: decoded type of the fetched instruction (package enum).
- `ifu_reqValid` out 1: fetch request.
- `lsu_reqValid` out 1: load/store request.
- `lsu_wen` out 1: the LSU request is a store.
- `pc_wen` out 1: PC update strobe.
- `reg_wen` out 1: register-file write strobe.
- `finished` out 1: one-cycle pulse, one cycle after each retirement.
- `ebreak` out 1: sticky; EBREAK retired.
- `trap` out 1: sticky; bus error or timeout.
- `trap_cause` out 2: `CAUSE_NONE`, `CAUSE_IFU_ERR`, `CAUSE_LSU_ERR`, `CAUSE_TIMEOUT`.
- `cycle_cnt` out `CNT_W`: cycles since reset, frozen in HALT.
- `instret_cnt` out `CNT_W`: retired instructions.

## Operation
- States: START, FETCH, LOAD, STORE, EXEC, HALT.
- **START** (the reset state):
  - assert `ifu_reqValid`;
  - next state is FETCH.
- **FETCH**:
  - assert `ifu_reqValid` until an accepted response.
  - A response is accepted only when `ifu_respValid && ifu_inflight`.
  - On acceptance with no error, `pc_wen=1` and then:
    - load types → LOAD, with `lsu_reqValid=1`;
    - store types → STORE, with `lsu_reqValid=1` and `lsu_wen=1`;
    - all other types → EXEC, with `reg_wen=1`.
- **LOAD**:
  - hold `lsu_reqValid` until an accepted response;
  - on acceptance, `reg_wen=1`, next state is EXEC.
- **STORE**:
  - hold `lsu_reqValid` and `lsu_wen` until an accepted response;
  - on acceptance, retire: assert `ifu_reqValid` and go to FETCH.
- **EXEC**:
  - retire;
  - if `inst_type == INST_EBREAK`, go to HALT and set `ebreak`;
  - otherwise assert `ifu_reqValid` and go to FETCH.
- **HALT**:
  - terminal; all request and enable outputs are 0;
  - only `reset` leaves it.
- **Inflight tracking**:
  - `*_inflight` is set on any cycle where the matching `*_reqValid=1`;
  - it is cleared on an accepted response;
  - it is cleared by reset.
  - A response arriving while not inflight is ignored: no state change, no error.
- **Bus errors**:
  - an accepted response with `*_respErr=1` → HALT;
  - set `trap` and the matching cause;
  - suppress `pc_wen`, `reg_wen` and `lsu_reqValid` on that cycle;
  - no retirement.
- **Timeout**:
  - `wait_cnt` resets to 0 on every state change and increments each cycle in FETCH, LOAD or STORE without an accepted response;
  - when `wait_cnt == TIMEOUT-1` and there is still no response → HALT, `trap=1`, `CAUSE_TIMEOUT`.
- **Retirement**:
  - defined as the EXEC cycle, or a STORE acceptance;
  - `instret_cnt` increments by 1 on retirement;
  - `finished` pulses on the following cycle.
- **Counters**: `cycle_cnt` increments every non-reset cycle while not in HALT. Both counters wrap modulo 2^CNT_W.
- **Sticky flags**: once `trap` is set, `trap_cause` holds until reset. `ebreak` and `trap` are never both set.

## Timing
- Reset values:
  - state START;
  - all outputs 0;
  - `trap_cause = CAUSE_NONE`;
  - counters 0.
- Output timing:
  - `*_reqValid`, `pc_wen`, `reg_wen` and `lsu_wen` are combinational from the state and inputs;
  - `finished`, `ebreak`, `trap`, `trap_cause` and the counters are registered.
- Best-case latency, counted from the accepted-fetch cycle:
  - ALU op: 2 cycles (FETCH accept, EXEC);
  - load: FETCH + LOAD accept + EXEC;
  - store: FETCH + STORE accept.
- A zero-wait response is allowed in the cycle right after the request (inflight is already set).
- Reset mid-transaction: on the next cycle the state is START and inflight is clear. A late response is therefore dropped.
- Error and timeout in the same cycle: error wins. A response on the timeout cycle is accepted normally.

## Structure
- `ctrl_pkg` holds:
  - the state enum;
  - the `inst_type` enum and `INST_TYPE_W`;
  - the `CAUSE_*` localparams;
  - a helper function `is_load()`/`is_store()`.
- One sub-module: `wait_timer`, the parametrised wait counter with clear and expire outputs. It is instantiated once.
- A verilator-only state-name debug string is permitted.

## Test plan
- **ALU stream.** 3 ALU instructions, zero-wait IFU → `finished` pulses 3 times, `instret_cnt=3`, `pc_wen` high exactly 3 cycles.
- **Load with LSU wait.** Load with a 5-cycle LSU delay → `lsu_reqValid` held 5 cycles, `reg_wen` on the accept cycle, then EXEC, `instret_cnt=1`.
- **Store retirement.** Store, then EBREAK → store retires without `reg_wen`; EBREAK gives `ebreak=1`, HALT, `cycle_cnt` frozen, no further `ifu_reqValid`.
- **Bus error.** IFU responds with `respErr=1` → `trap=1`, `trap_cause=CAUSE_IFU_ERR`, `pc_wen=0`, `instret_cnt` unchanged.
- **Timeout.** `TIMEOUT=8`, LSU never responds → HALT after exactly 8 LOAD cycles with `CAUSE_TIMEOUT`. With `TIMEOUT=0` it waits indefinitely.
- **Reset mid-fetch and wrap.**
  - Reset during FETCH, with `ifu_respValid` arriving in the cycle after reset → the response is ignored and the FSM restarts in START.
  - `CNT_W=4` with 17 retirements → `instret_cnt=1`.
